// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// hold/flush handling and a saturating bubble counter.
module id_ex_stage_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic [6:0]       id_funct7,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             id_alu_src,
  input  logic             id_branch,
  input  logic [1:0]       id_alu_op,
  output logic             hazard_stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic [6:0]       ex_funct7,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_alu_src,
  output logic             ex_branch,
  output logic [1:0]       ex_alu_op,
  output logic [CNT_W-1:0] bubble_count
);

  logic load_use;
  logic insert_bubble;
  logic count_sat;

  // rs2 is compared even for formats without an rs2 field; a spurious stall
  // is cheaper than decoding the format here.
  assign load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  assign hazard_stall  = load_use & ~flush & ~hold;
  assign insert_bubble = flush | (~hold & load_use);
  assign count_sat     = (bubble_count == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (reset || insert_bubble) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_funct3     <= '0;
      ex_funct7     <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= 2'b00;
    end else if (!hold) begin
      ex_valid      <= id_valid;
      ex_pc         <= id_pc;
      ex_rs1_data   <= id_rs1_data;
      ex_rs2_data   <= id_rs2_data;
      ex_imm        <= id_imm;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_funct3     <= id_funct3;
      ex_funct7     <= id_funct7;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_alu_src    <= id_alu_src;
      ex_branch     <= id_branch;
      ex_alu_op     <= id_alu_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (insert_bubble && !count_sat) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule
